seq_shifter: RTL
================

Name: seq_shifter

Overview:
Parametrised multi-cycle barrel-shift unit for the processor datapath. It generalises the fixed single-bit left shift to any width, to a runtime shift amount and to four shift modes. It shifts by up to STEP bits per clock. A valid/ready handshake on input and output lets it sit beside the multdiv unit as a stallable functional unit.

Parameters:
WIDTH, 32, operand/result width; must be a power of two, >= 2
STEP, 4, maximum bits shifted per clock; power of two, 1 <= STEP <= WIDTH
SHAMT_W, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous abort of any in-flight operation
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
in_data  in  WIDTH  operand
in_shamt  in  SHAMT_W  shift amount, unsigned, 0..WIDTH-1
in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  shifted value
out_carry  out  1  last bit shifted/rotated out
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, SHIFT, DONE. Registers: state, acc[WIDTH], rem[SHAMT_W], mode, carry.
- reset low, at any time including mid-operation: state=IDLE, acc=0, rem=0, carry=0, mode=0. Effect is immediate, with no clock required.
- Outputs decoded from state:
  - in_ready = (state==IDLE)
  - out_valid = (state==DONE)
  - busy = (state!=IDLE)
  - out_result = acc and out_carry = carry in all states.
  - Reset values are therefore in_ready=1, out_valid=0, busy=0, out_result=0, out_carry=0.
- IDLE: on an edge with in_valid && !flush, capture acc=in_data, rem=in_shamt, mode=in_mode and carry=0.
  - If in_shamt==0, go to DONE.
  - Otherwise, go to SHIFT.
- SHIFT: each edge, k = min(rem, STEP). Shift acc by k per mode, then rem -= k.
  - If rem-k==0, go to DONE; otherwise stay in SHIFT.
  - in_valid is ignored because in_ready=0.
- Per-mode shift rules:
  - SLL: zero-fill at the LSB.
  - SRL: zero-fill at the MSB.
  - SRA: replicate acc[WIDTH-1].
  - ROL: bits leaving the MSB enter at the LSB.
- carry = last bit leaving acc in that step:
  - SLL/ROL: acc[WIDTH-k]
  - SRL/SRA: acc[k-1]
- Net carry over the whole operation:
  - SLL/ROL: in_data[WIDTH-s]
  - SRL/SRA: in_data[s-1]
  - s=0: 0
- Latency: out_valid rises 1+ceil(s/STEP) edges after the accepting edge (1 edge for s=0). Example: WIDTH=32, STEP=4, s=31 gives 9 edges.
- DONE: out_result and out_carry are held stable while out_ready=0 (backpressure).
  - Edge with out_ready=1: go to IDLE. acc and carry keep their value until the next accept.
  - The next request can be accepted at the earliest one edge after the result is consumed (no same-cycle turnaround).
- flush=1 at an edge, from any state: go to IDLE and discard the operation.
  - flush beats in_valid in IDLE, so the request is not accepted.
  - flush beats SHIFT progress.
  - flush in DONE together with out_ready behaves as a normal consume.
- The result equals the single-shot reference shift for every mode, shamt and STEP. Multi-step composition must not change SRA sign or ROL wrap.

Test Plan:
1. WIDTH=32, STEP=4, SLL 0x0000_0001 by 5 -> out_result=0x0000_0020, out_carry=0, out_valid 3 edges after accept, in_ready=0 meanwhile.
2. SRA 0xF000_0000 by 4 -> 0xFF00_0000, carry=0, 2 edges. SRL 0x8000_0000 by 31 -> 0x0000_0001, carry=0, 9 edges. ROL 0x8000_0001 by 1 -> 0x0000_0003, carry=1, 2 edges.
3. shamt=0, mode SRA, data 0xDEAD_BEEF -> result 0xDEAD_BEEF, carry=0, out_valid 1 edge after accept.
4. Backpressure: complete SLL 0x1 by 1, hold out_ready=0 for 5 cycles while driving in_valid=1 with new data -> result stays 0x2, out_valid stays 1, the new request is not accepted. Raise out_ready -> IDLE next edge, then the new request is accepted.
5. Abort: accept SRL by 20, assert flush on the 2nd SHIFT edge -> IDLE, out_valid never asserts. Assert flush together with in_valid in IDLE -> request not accepted.
6. Reset: drive reset low mid-SHIFT asynchronously (between edges) -> out_result=0, out_carry=0, out_valid=0, busy=0, in_ready=1 immediately. Release reset, issue ROL 0x1 by 31 -> 0x8000_0000, carry=0.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-shift unit with valid/ready handshakes.
// Shifts an operand by a runtime amount, at most STEP bits per clock, in one of
// four modes (SLL, SRL, SRA, ROL). out_carry reports the last bit shifted out.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   flush       synchronous abort of any in-flight operation
//   in_valid    request valid            in_ready   unit can accept a request
//   in_data     operand                  in_shamt   shift amount (0..WIDTH-1)
//   in_mode     00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid   result valid             out_ready  consumer accepts result
//   out_result  shifted value            out_carry  last bit shifted/rotated out
//   busy        unit not idle
module seq_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 4,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_carry,
  output logic               busy
);

  // One extra bit so STEP == WIDTH is representable.
  localparam int unsigned KW = SHAMT_W + 1;
  localparam logic [KW-1:0] StepK  = KW'(STEP);
  localparam logic [KW-1:0] WidthK = KW'(WIDTH);

  localparam logic [1:0] ModeSll = 2'b00;
  localparam logic [1:0] ModeSrl = 2'b01;
  localparam logic [1:0] ModeSra = 2'b10;
  localparam logic [1:0] ModeRol = 2'b11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             r_state_q, r_state_d;
  logic [WIDTH-1:0]   r_acc_q, r_acc_d;
  logic [SHAMT_W-1:0] r_rem_q, r_rem_d;
  logic [1:0]         r_mode_q, r_mode_d;
  logic               r_carry_q, r_carry_d;

  logic [KW-1:0]    w_rem_ext;
  logic [KW-1:0]    w_k;
  logic [KW-1:0]    w_idx_hi;
  logic [KW-1:0]    w_idx_lo;
  logic [WIDTH-1:0] w_shifted;
  logic             w_carry;

  // Per-step shift amount k = min(rem, STEP).
  assign w_rem_ext = {1'b0, r_rem_q};
  assign w_k       = (w_rem_ext < StepK) ? w_rem_ext : StepK;
  // Index of the last bit leaving at the MSB side (WIDTH-k) or LSB side (k-1).
  // Only meaningful in StShift, where k >= 1.
  assign w_idx_hi  = WidthK - w_k;
  assign w_idx_lo  = w_k - KW'(1);

  always_comb begin
    w_shifted = r_acc_q;
    w_carry   = 1'b0;
    unique case (r_mode_q)
      ModeSll: begin
        w_shifted = r_acc_q << w_k;
        w_carry   = r_acc_q[w_idx_hi[SHAMT_W-1:0]];
      end
      ModeSrl: begin
        w_shifted = r_acc_q >> w_k;
        w_carry   = r_acc_q[w_idx_lo[SHAMT_W-1:0]];
      end
      ModeSra: begin
        w_shifted = $unsigned($signed(r_acc_q) >>> w_k);
        w_carry   = r_acc_q[w_idx_lo[SHAMT_W-1:0]];
      end
      ModeRol: begin
        w_shifted = (r_acc_q << w_k) | (r_acc_q >> w_idx_hi);
        w_carry   = r_acc_q[w_idx_hi[SHAMT_W-1:0]];
      end
      default: begin
        w_shifted = r_acc_q;
        w_carry   = 1'b0;
      end
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_acc_d   = r_acc_q;
    r_rem_d   = r_rem_q;
    r_mode_d  = r_mode_q;
    r_carry_d = r_carry_q;
    if (flush) begin
      // Abort wins over acceptance and progress; datapath registers are left as-is.
      r_state_d = StIdle;
    end else begin
      case (r_state_q)
        StIdle: begin
          if (in_valid) begin
            r_acc_d   = in_data;
            r_rem_d   = in_shamt;
            r_mode_d  = in_mode;
            r_carry_d = 1'b0;
            r_state_d = (in_shamt == '0) ? StDone : StShift;
          end
        end
        StShift: begin
          r_acc_d   = w_shifted;
          r_carry_d = w_carry;
          r_rem_d   = r_rem_q - w_k[SHAMT_W-1:0];
          if (w_rem_ext == w_k) begin
            r_state_d = StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state_d = StIdle;
          end
        end
        default: r_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state_q <= StIdle;
      r_acc_q   <= '0;
      r_rem_q   <= '0;
      r_mode_q  <= 2'b00;
      r_carry_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_acc_q   <= r_acc_d;
      r_rem_q   <= r_rem_d;
      r_mode_q  <= r_mode_d;
      r_carry_q <= r_carry_d;
    end
  end

  assign in_ready   = (r_state_q == StIdle);
  assign out_valid  = (r_state_q == StDone);
  assign busy       = (r_state_q != StIdle);
  assign out_result = r_acc_q;
  assign out_carry  = r_carry_q;

endmodule
